// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: FSM states, BCD digit type
// and the wrap-around digit increment.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_L = 2'd2,
        LOAD   = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/time_setter_if.sv
// Button inputs, load handshake and status bundle of the time setter.
// master = time_setter side, slave = counter/user side.
interface time_setter_if;
    import countdown_pkg::*;

    logic btn_mode;
    logic btn_inc;
    logic btn_start;
    logic load_ack;
    bcd_t set_h;
    bcd_t set_l;
    logic load_req;
    logic editing;
    logic edit_digit;
    logic blink;

    modport master (
        input  btn_mode, btn_inc, btn_start, load_ack,
        output set_h, set_l, load_req, editing, edit_digit, blink
    );

    modport slave (
        output btn_mode, btn_inc, btn_start, load_ack,
        input  set_h, set_l, load_req, editing, edit_digit, blink
    );

endinterface

// File: rtl/time_setter_button_debounce.sv
// 2-FF synchroniser, stability counter and registered rise-edge pulse.
// Press pulse arrives 2 + DEBOUNCE_CYCLES + 1 cycles after a clean press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          level_dly_q;
    logic          press_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_i};
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            // any cycle back at the accepted level restarts the count
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/time_setter.sv
// Button-driven editor for the two-digit BCD start value with load handshake.
// Optional auto-repeat on btn_inc: define TIME_SETTER_AUTO_REPEAT_EN.
module time_setter
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int BLINK_CYCLES    = 250000,
    parameter int DEFAULT_H       = 6,
    parameter int DEFAULT_L       = 0,
    parameter int REPEAT_CYCLES   = 100000
) (
    input  logic          clock,
    input  logic          reset,
    time_setter_if.master bus
);

    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic mode_lvl, mode_p;
    logic inc_lvl, inc_p;
    logic start_lvl, start_p;
    logic inc_ev;
    logic nz;

    state_e        state_q;
    bcd_t          set_h_q, set_l_q;
    logic          load_req_q, editing_q, edit_digit_q, blink_q;
    logic [BW-1:0] blink_cnt_q;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clock(clock), .reset(reset), .btn_i(bus.btn_mode),
        .level_o(mode_lvl), .press_o(mode_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clock(clock), .reset(reset), .btn_i(bus.btn_inc),
        .level_o(inc_lvl), .press_o(inc_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clock(clock), .reset(reset), .btn_i(bus.btn_start),
        .level_o(start_lvl), .press_o(start_p)
    );

    logic unused_lvl;
    assign unused_lvl = &{mode_lvl, start_lvl, inc_lvl, REPEAT_CYCLES != 0};

`ifdef TIME_SETTER_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rpt_cnt_q;
    logic          rpt_fire;

    assign rpt_fire = (rpt_cnt_q == RW'(REPEAT_CYCLES - 1));

    // restarts on release, any press pulse, leaving edit, and each fire
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_cnt_q <= '0;
        end else if (!inc_lvl || !editing_q || inc_p || mode_p ||
                     start_p || rpt_fire) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
        end
    end

    assign inc_ev = inc_p | rpt_fire;
`else
    assign inc_ev = inc_p;
`endif

    assign nz = (set_h_q != 4'd0) || (set_l_q != 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            set_h_q      <= 4'(DEFAULT_H);
            set_l_q      <= 4'(DEFAULT_L);
            load_req_q   <= 1'b0;
            editing_q    <= 1'b0;
            edit_digit_q <= 1'b0;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
        end else begin
            if (editing_q) begin
                if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                    blink_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end else begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
            end

            unique case (state_q)
                IDLE, EDIT_H, EDIT_L: begin
                    // start wins the cycle even when 00 blocks the load
                    if (start_p) begin
                        if (nz) begin
                            state_q      <= LOAD;
                            load_req_q   <= 1'b1;
                            editing_q    <= 1'b0;
                            edit_digit_q <= 1'b0;
                            blink_q      <= 1'b0;
                            blink_cnt_q  <= '0;
                        end
                    end else if (mode_p) begin
                        editing_q <= 1'b1;
                        if (state_q == EDIT_H) begin
                            state_q      <= EDIT_L;
                            edit_digit_q <= 1'b0;
                        end else begin
                            state_q      <= EDIT_H;
                            edit_digit_q <= 1'b1;
                        end
                    end else if (inc_ev) begin
                        if (state_q == EDIT_H) set_h_q <= bcd_inc(set_h_q);
                        if (state_q == EDIT_L) set_l_q <= bcd_inc(set_l_q);
                    end
                end
                LOAD: begin
                    if (bus.load_ack) begin
                        state_q    <= IDLE;
                        load_req_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.set_h      = set_h_q;
    assign bus.set_l      = set_l_q;
    assign bus.load_req   = load_req_q;
    assign bus.editing    = editing_q;
    assign bus.edit_digit = edit_digit_q;
    assign bus.blink      = blink_q;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: loaded values are queued at start
// presses and compared when load_req rises.
module tb_time_setter;

    localparam int DEB = 4;
    localparam int BLK = 8;
    localparam int RPT = 16;
    localparam int HOLD = DEB + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic auto_ack = 1'b1;
    logic ack_auto = 1'b0;
    logic ack_man = 1'b0;
    logic lreq_prev = 1'b0;
    int   ack_wait = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] exp_q[$];

    time_setter_if bus();

    time_setter #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES(BLK),
        .DEFAULT_H(6),
        .DEFAULT_L(0),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.load_ack = ack_man | ack_auto;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // counter side: single-cycle ack a few cycles after load_req rises
    always @(negedge clk) begin
        if (auto_ack && bus.load_req && !ack_auto) begin
            if (ack_wait == 2) begin
                ack_auto <= 1'b1;
                ack_wait <= 0;
            end else begin
                ack_wait <= ack_wait + 1;
            end
        end else begin
            ack_auto <= 1'b0;
            if (!bus.load_req) ack_wait <= 0;
        end
    end

    always @(negedge clk) begin
        lreq_prev <= bus.load_req;
        if (bus.load_req && !lreq_prev && !rst) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_load", 1, 0);
            end else begin
                chk("load_value", int'({bus.set_h, bus.set_l}),
                    int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i, input logic s);
        bus.btn_mode  = m;
        bus.btn_inc   = i;
        bus.btn_start = s;
        cyc(HOLD);
        bus.btn_mode  = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_start = 1'b0;
        cyc(HOLD);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.load_req && n < 50) begin
            cyc(1);
            n++;
        end
        chk("load_drop", int'(bus.load_req), 0);
    endtask

    task automatic start_load(input logic [3:0] h, input logic [3:0] l);
        exp_q.push_back({h, l});
        press(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int toggles;
        logic prev_b;
        bus.btn_mode  = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_start = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        // reset state
        chk("rst_set_h", int'(bus.set_h), 6);
        chk("rst_set_l", int'(bus.set_l), 0);
        chk("rst_load_req", int'(bus.load_req), 0);
        chk("rst_editing", int'(bus.editing), 0);
        chk("rst_edit_digit", int'(bus.edit_digit), 0);
        chk("rst_blink", int'(bus.blink), 0);

        // load defaults
        start_load(4'd6, 4'd0);
        wait_idle();
        chk("t1_keep_h", int'(bus.set_h), 6);
        chk("t1_keep_l", int'(bus.set_l), 0);

        // edit tens with wrap, then units
        press(1'b1, 1'b0, 1'b0);
        chk("t2_editing", int'(bus.editing), 1);
        chk("t2_digit_h", int'(bus.edit_digit), 1);
        toggles = 0;
        prev_b = bus.blink;
        for (int k = 0; k < 2 * BLK; k++) begin
            cyc(1);
            if (bus.blink != prev_b) toggles++;
            prev_b = bus.blink;
        end
        chk("t2_blink_toggles", toggles, 2);
        for (int k = 0; k < 4; k++) begin
            press(1'b0, 1'b1, 1'b0);
            chk("t2_inc_h", int'(bus.set_h), (7 + k) % 10);
        end
        press(1'b1, 1'b0, 1'b0);
        chk("t2_digit_l", int'(bus.edit_digit), 0);
        chk("t2_still_edit", int'(bus.editing), 1);
        repeat (3) press(1'b0, 1'b1, 1'b0);
        chk("t2_set_l", int'(bus.set_l), 3);
        start_load(4'd0, 4'd3);
        wait_idle();
        chk("t2_idle_edit", int'(bus.editing), 0);
        chk("t2_idle_blink", int'(bus.blink), 0);

        // start with 00 is ignored
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        repeat (7) press(1'b0, 1'b1, 1'b0);
        chk("t3_zero_l", int'(bus.set_l), 0);
        chk("t3_zero_h", int'(bus.set_h), 0);
        press(1'b0, 1'b0, 1'b1);
        chk("t3_no_load", int'(bus.load_req), 0);
        chk("t3_still_edit", int'(bus.editing), 1);
        chk("t3_still_l", int'(bus.edit_digit), 0);
        press(1'b0, 1'b1, 1'b0);
        start_load(4'd0, 4'd1);
        wait_idle();

        // glitch rejection and bounce inside a held press
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        bus.btn_inc = 1'b1;
        cyc(3);
        bus.btn_inc = 1'b0;
        cyc(HOLD);
        chk("t4_glitch", int'(bus.set_l), 1);
        bus.btn_inc = 1'b1;
        cyc(10);
        bus.btn_inc = 1'b0;
        cyc(1);
        bus.btn_inc = 1'b1;
        cyc(10);
        bus.btn_inc = 1'b0;
        cyc(HOLD);
        chk("t4_bounce", int'(bus.set_l), 2);

        // value 45, then mode+start together in EDIT_H
        press(1'b1, 1'b0, 1'b0);
        repeat (4) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        repeat (3) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("t5_pre_digit", int'(bus.edit_digit), 1);
        auto_ack = 1'b0;
        exp_q.push_back(8'h45);
        press(1'b1, 1'b0, 1'b1);
        chk("t5_load_req", int'(bus.load_req), 1);
        chk("t5_digit", int'(bus.edit_digit), 0);
        chk("t5_editing", int'(bus.editing), 0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("t5_frozen", int'({bus.set_h, bus.set_l}), 8'h45);
        chk("t5_hold_req", int'(bus.load_req), 1);
        chk("t5_hold_edit", int'(bus.editing), 0);
        ack_man = 1'b1;
        cyc(1);
        ack_man = 1'b0;
        cyc(1);
        chk("t5_ack_drop", int'(bus.load_req), 0);
        ack_man = 1'b1;
        cyc(2);
        ack_man = 1'b0;
        chk("t5_stray_ack", int'(bus.load_req), 0);

        // reset during LOAD
        start_load(4'd4, 4'd5);
        chk("t6_req", int'(bus.load_req), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_req", int'(bus.load_req), 0);
        chk("t6_async_val", int'({bus.set_h, bus.set_l}), 8'h60);
        cyc(2);
        rst = 1'b0;
        auto_ack = 1'b1;
        cyc(2);

`ifdef TIME_SETTER_AUTO_REPEAT_EN
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        bus.btn_inc = 1'b1;
        cyc(2 * RPT + DEB + 6);
        bus.btn_inc = 1'b0;
        cyc(HOLD + 4);
        chk("t6_repeat", int'(bus.set_l), 3);
`endif

        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_setter.md
Name: time_setter

Overview:
User-entry front end for the countdown timer. It debounces three push-buttons and lets the user edit a two-digit BCD start value (tens and units). It then hands that value to the counter over a req/ack load handshake. It is the writer side of the counter's time value; the counter reads the value, counts it down, and drives the display and beep.

Parameters:
DEBOUNCE_CYCLES, 20000, clock cycles a synchronised button level must stay stable before it is accepted
BLINK_CYCLES, 250000, half-period in clock cycles of the blink output while editing
DEFAULT_H, 6, tens digit after reset (0-9)
DEFAULT_L, 0, units digit after reset (0-9)
REPEAT_CYCLES, 100000, auto-repeat interval for btn_inc (used only when TIME_SETTER_AUTO_REPEAT_EN is defined)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_mode  in  1  raw button, asynchronous, active-high: enter edit mode / select next digit
btn_inc  in  1  raw button, active-high: increment the selected digit
btn_start  in  1  raw button, active-high: commit the value and start
load_ack  in  1  counter accepted the value; single-cycle pulse or level
set_h  out  4  BCD tens digit, 0-9
set_l  out  4  BCD units digit, 0-9
load_req  out  1  value on set_h/set_l is valid and must be loaded
editing  out  1  high in EDIT_H or EDIT_L
edit_digit  out  1  0 = units selected, 1 = tens selected
blink  out  1  toggles every BLINK_CYCLES while editing; 0 otherwise

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE
  - set_h = DEFAULT_H, set_l = DEFAULT_L
  - load_req = 0, editing = 0, edit_digit = 0, blink = 0
  - all debounce counters and synchronisers cleared.
- Button conditioning:
  - Each button passes through a 2-FF synchroniser, then a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new level.
  - The rising edge of the accepted level produces a 1-cycle press pulse.
  - Latency from a stable raw press to the pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - A release/glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Same-cycle press priority: start > mode > inc. Lower-priority pulses in that cycle are dropped.
- FSM:
  - IDLE:
    - mode -> EDIT_H.
    - start with value != 00 -> LOAD.
    - inc is ignored.
  - EDIT_H:
    - inc: set_h = (set_h == 9) ? 0 : set_h + 1.
    - mode -> EDIT_L.
    - start with value != 00 -> LOAD.
  - EDIT_L:
    - inc: set_l wraps 9 -> 0 the same way; no carry into set_h.
    - mode -> EDIT_H.
    - start with value != 00 -> LOAD.
  - LOAD:
    - load_req = 1 from the cycle after entry.
    - set_h/set_l are frozen; all button pulses are ignored.
    - On the first cycle with load_ack = 1: load_req drops the next cycle and state -> IDLE.
    - load_ack seen outside LOAD is ignored.
  - start with value 00 is ignored in every state; the state is unchanged.
- Value retention: set_h/set_l keep the last edited value across loads. A new edit starts from that value, not from the defaults.
- Status outputs:
  - editing = 1 exactly in EDIT_H/EDIT_L.
  - edit_digit = 1 in EDIT_H; 0 in all other states.
- blink:
  - The counter runs only while editing. Output toggles when the count reaches BLINK_CYCLES-1, then the count restarts.
  - Leaving the edit states forces blink = 0 and clears the counter.
  - Switching digit does not restart the blink counter.
- Reset asserted mid-LOAD: load_req drops immediately (async) and the values return to the defaults.
- All outputs are registered.

Optional Feature:
TIME_SETTER_AUTO_REPEAT_EN
- Defined:
  - In EDIT_H/EDIT_L, while btn_inc stays accepted-high, one extra increment fires every REPEAT_CYCLES after the initial press pulse.
  - The repeat counter clears on release or on a state change.
- Undefined: one increment per press only; the repeat counter logic is absent.

Decomposition:
- Shared package countdown_pkg holds:
  - state typedef (IDLE, EDIT_H, EDIT_L, LOAD)
  - BCD_MAX = 4'd9
  - the 4-bit BCD digit typedef.
- One sub-module, button_debounce: synchroniser + debounce + rise-edge pulse, parameterised by DEBOUNCE_CYCLES. It outputs the accepted level and the press pulse, and is instantiated three times.

Test Plan:
Sim parameters: DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, REPEAT_CYCLES=16.
1. Reset -> set_h=6, set_l=0, load_req=0, editing=0, blink=0; press start -> LOAD, load_req=1 until a single-cycle load_ack; then IDLE with 60 retained.
2. Press mode, then inc x4 -> set_h wraps 6,7,8,9,0; press mode, then inc x3 -> set_l=3; start -> set_h=0, set_l=3 presented with load_req.
3. Set the value to 00 and press start -> state unchanged, load_req stays 0; then inc units once -> start accepted with 01.
4. btn_inc glitch of 3 cycles -> no increment; 1-cycle bounce inside a held press -> exactly one increment.
5. mode and start pressed in the same cycle while in EDIT_H with 45 -> LOAD entered, edit_digit = 0; presses during LOAD change nothing.
6. Assert reset while load_req=1 -> load_req=0 immediately and value = 60. With TIME_SETTER_AUTO_REPEAT_EN, holding inc for 2*REPEAT_CYCLES in EDIT_L from 0 -> set_l=3.
